// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard front end: synchronises and deserialises frames, buffers good bytes
// in a small FIFO and tracks make/break codes into a held scan code plus key state.
module ps2_scan_receiver #(
    parameter int unsigned FIFO_AW     = 3,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       key_down,
    output logic       key_valid,
    output logic       key_release,
    output logic       extended,
    output logic [7:0] key_count,
    output logic       frame_err,
    output logic       overflow
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [0:0]  ST_MAKE  = 1'b0;
    localparam logic [0:0]  ST_BREAK = 1'b1;

    // Synchronisers; reset to the idle-high line level
    logic       c1_q, c2_q, c3_q, d1_q, d2_q;
    logic       fall_c;
    logic [10:0] shift_q, shift_d, frame_c;
    logic [3:0]  cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic       push_q, push_d, ferr_q, ferr_d;
    logic [7:0] pdata_q, pdata_d;

    assign fall_c  = c3_q & ~c2_q;
    assign frame_c = {d2_q, shift_q[10:1]};

    // Frame deserialiser, checker and mid-frame timeout
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        tmr_d   = '0;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
        pdata_d = pdata_q;
        if (fall_c) begin
            shift_d = frame_c;
            if (cnt_q == 4'd10) begin
                cnt_d = 4'd0;
                if (!frame_c[0] && frame_c[10] && (^frame_c[9:1])) begin
                    push_d  = 1'b1;
                    pdata_d = frame_c[8:1];
                end else begin
                    ferr_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else if (cnt_q != 4'd0) begin
            if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
                cnt_d = 4'd0;
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c1_q <= 1'b1; c2_q <= 1'b1; c3_q <= 1'b1;
            d1_q <= 1'b1; d2_q <= 1'b1;
            shift_q <= '0; cnt_q <= '0; tmr_q <= '0;
            push_q <= 1'b0; ferr_q <= 1'b0; pdata_q <= '0;
        end else begin
            c1_q <= ps2_clk; c2_q <= c1_q; c3_q <= c2_q;
            d1_q <= ps2_data; d2_q <= d1_q;
            shift_q <= shift_d; cnt_q <= cnt_d; tmr_q <= tmr_d;
            push_q <= push_d; ferr_q <= ferr_d; pdata_q <= pdata_d;
        end
    end

    // Byte FIFO; extra pointer bit separates full from empty
    logic [7:0]       mem_q [DEPTH];
    logic [FIFO_AW:0] wr_q, rd_q;
    logic             empty_c, full_c, pop_c, wr_en_c, ovf_q;
    logic [7:0]       byte_q;
    logic             byte_vld_q;

    assign empty_c = (wr_q == rd_q);
    assign full_c  = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) &&
                     (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
    assign pop_c   = !empty_c;
    assign wr_en_c = push_q && (!full_c || pop_c);

    always_ff @(posedge clk) begin
        if (wr_en_c) mem_q[wr_q[FIFO_AW-1:0]] <= pdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0; rd_q <= '0; ovf_q <= 1'b0;
            byte_q <= '0; byte_vld_q <= 1'b0;
        end else begin
            if (wr_en_c) wr_q <= wr_q + (FIFO_AW+1)'(1);
            if (pop_c)   rd_q <= rd_q + (FIFO_AW+1)'(1);
            if (push_q && full_c && !pop_c) ovf_q <= 1'b1;
            byte_vld_q <= pop_c;
            if (pop_c) byte_q <= mem_q[rd_q[FIFO_AW-1:0]];
        end
    end

    // Make/break tracker
    logic [0:0] state_q, state_d;
    logic [7:0] scan_q, scan_d, count_q, count_d;
    logic       down_q, down_d, ext_q, ext_d, extp_q, extp_d;
    logic       kv_q, kv_d, rel_q, rel_d;

    always_comb begin
        state_d = state_q;
        scan_d  = scan_q;
        count_d = count_q;
        down_d  = down_q;
        ext_d   = ext_q;
        extp_d  = extp_q;
        kv_d    = 1'b0;
        rel_d   = 1'b0;
        if (byte_vld_q) begin
            case (state_q)
                ST_MAKE: begin
                    if (byte_q == 8'hE0) begin
                        extp_d = 1'b1;
                    end else if (byte_q == 8'hF0) begin
                        state_d = ST_BREAK;
                    end else if (!(byte_q == scan_q && down_q)) begin
                        scan_d  = byte_q;
                        ext_d   = extp_q;
                        down_d  = 1'b1;
                        kv_d    = 1'b1;
                        count_d = count_q + 8'd1;
                        extp_d  = 1'b0;
                    end
                end
                default: begin
                    if (byte_q == 8'hE0) begin
                        extp_d = 1'b1;
                    end else begin
                        if (byte_q == scan_q) begin
                            down_d = 1'b0;
                            rel_d  = 1'b1;
                        end
                        state_d = ST_MAKE;
                        extp_d  = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_MAKE; scan_q <= '0; count_q <= '0;
            down_q <= 1'b0; ext_q <= 1'b0; extp_q <= 1'b0;
            kv_q <= 1'b0; rel_q <= 1'b0;
        end else begin
            state_q <= state_d; scan_q <= scan_d; count_q <= count_d;
            down_q <= down_d; ext_q <= ext_d; extp_q <= extp_d;
            kv_q <= kv_d; rel_q <= rel_d;
        end
    end

    assign scan_code   = scan_q;
    assign key_down    = down_q;
    assign key_valid   = kv_q;
    assign key_release = rel_q;
    assign extended    = ext_q;
    assign key_count   = count_q;
    assign frame_err   = ferr_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: table of frames with expected tracker state,
// plus hand-written timeout, overflow and mid-frame reset sequences.
module tb_ps2_scan_receiver;
    localparam int unsigned TIMEOUT = 5000;
    localparam int unsigned HALF    = 10;

    logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] scan_code, key_count;
    logic       key_down, key_valid, key_release, extended, frame_err, overflow;

    int checks = 0, errors = 0;
    int kv_n = 0, rel_n = 0, fe_n = 0;

    ps2_scan_receiver #(.FIFO_AW(3), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scan_code(scan_code), .key_down(key_down), .key_valid(key_valid),
        .key_release(key_release), .extended(extended), .key_count(key_count),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid)   kv_n++;
        if (key_release) rel_n++;
        if (frame_err)   fe_n++;
    end

    typedef struct {
        logic [7:0] code;
        logic       flip_par;
        logic       bad_stop;
        logic [7:0] exp_scan;
        logic       exp_down;
        logic       exp_ext;
        logic [7:0] exp_count;
        int         exp_kv;
        int         exp_rel;
        int         exp_fe;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic bad_stop);
        logic [10:0] f;
        f = {~bad_stop, (~^d) ^ flip_par, d, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int kv0, rel0, fe0;
        // code, par flip, stop bad, scan, down, ext, count, kv, rel, fe
        vecs[0]  = '{8'h1C, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b0, 8'd1, 1, 0, 0};
        vecs[1]  = '{8'h1C, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b0, 8'd1, 0, 0, 0};
        vecs[2]  = '{8'h1C, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b0, 8'd1, 0, 0, 0};
        vecs[3]  = '{8'h1C, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b0, 8'd1, 0, 0, 0};
        vecs[4]  = '{8'hF0, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b0, 8'd1, 0, 0, 0};
        vecs[5]  = '{8'h1C, 1'b0, 1'b0, 8'h1C, 1'b0, 1'b0, 8'd1, 0, 1, 0};
        vecs[6]  = '{8'hE0, 1'b0, 1'b0, 8'h1C, 1'b0, 1'b0, 8'd1, 0, 0, 0};
        vecs[7]  = '{8'h75, 1'b0, 1'b0, 8'h75, 1'b1, 1'b1, 8'd2, 1, 0, 0};
        vecs[8]  = '{8'h1D, 1'b0, 1'b0, 8'h1D, 1'b1, 1'b0, 8'd3, 1, 0, 0};
        vecs[9]  = '{8'h1C, 1'b1, 1'b0, 8'h1D, 1'b1, 1'b0, 8'd3, 0, 0, 1};
        vecs[10] = '{8'h1C, 1'b0, 1'b1, 8'h1D, 1'b1, 1'b0, 8'd3, 0, 0, 1};

        repeat (4) @(negedge clk);
        chk("reset scan_code", int'(scan_code), 0);
        chk("reset key_count", int'(key_count), 0);
        chk("reset key_down", int'(key_down), 0);
        chk("reset overflow", int'(overflow), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            kv0 = kv_n; rel0 = rel_n; fe0 = fe_n;
            send_frame(vecs[v].code, vecs[v].flip_par, vecs[v].bad_stop);
            chk($sformatf("v%0d scan_code", v), int'(scan_code), int'(vecs[v].exp_scan));
            chk($sformatf("v%0d key_down", v), int'(key_down), int'(vecs[v].exp_down));
            chk($sformatf("v%0d extended", v), int'(extended), int'(vecs[v].exp_ext));
            chk($sformatf("v%0d key_count", v), int'(key_count), int'(vecs[v].exp_count));
            chk($sformatf("v%0d key_valid pulses", v), kv_n - kv0, vecs[v].exp_kv);
            chk($sformatf("v%0d key_release pulses", v), rel_n - rel0, vecs[v].exp_rel);
            chk($sformatf("v%0d frame_err pulses", v), fe_n - fe0, vecs[v].exp_fe);
        end

        // Partial frame abandoned by timeout, then a clean frame
        fe0 = fe_n; kv0 = kv_n;
        for (int i = 0; i < 4; i++) ps2_bit(1'b0);
        repeat (TIMEOUT + 1) @(negedge clk);
        send_frame(8'h24, 1'b0, 1'b0);
        chk("timeout frame_err pulses", fe_n - fe0, 0);
        chk("timeout scan_code", int'(scan_code), 'h24);
        chk("timeout key_count", int'(key_count), 4);
        chk("timeout key_valid pulses", kv_n - kv0, 1);

        // Stall the tracker and overfill the FIFO
        force dut.pop_c = 1'b0;
        for (int i = 0; i < 8; i++) send_frame(8'(8'h30 + i), 1'b0, 1'b0);
        chk("fifo full no overflow", int'(overflow), 0);
        chk("stalled scan_code", int'(scan_code), 'h24);
        send_frame(8'h38, 1'b0, 1'b0);
        chk("overflow set", int'(overflow), 1);
        release dut.pop_c;
        repeat (30) @(negedge clk);
        chk("drain scan_code", int'(scan_code), 'h37);
        chk("drain key_count", int'(key_count), 12);
        chk("overflow sticky", int'(overflow), 1);

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) ps2_bit(1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst scan_code", int'(scan_code), 0);
        chk("midrst key_count", int'(key_count), 0);
        chk("midrst overflow", int'(overflow), 0);
        chk("midrst key_down", int'(key_down), 0);
        chk("midrst extended", int'(extended), 0);
        rst = 1'b0;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        kv0 = kv_n; fe0 = fe_n;
        send_frame(8'h24, 1'b0, 1'b0);
        chk("post-rst scan_code", int'(scan_code), 'h24);
        chk("post-rst key_count", int'(key_count), 1);
        chk("post-rst key_down", int'(key_down), 1);
        chk("post-rst key_valid pulses", kv_n - kv0, 1);
        chk("post-rst frame_err pulses", fe_n - fe0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
